// File: rtl/data_sync_rx.sv
// data_sync_rx: destination-side receiver of a four-phase req/ack handshake.
// The level request is resynchronised into i_clk, the source bus is sampled
// once the synchronised request is seen, a one-cycle valid strobe is issued
// and a level acknowledge is held until the request is withdrawn.
module data_sync_rx #(
   parameter int NUM_STAGES = 2,
   parameter int BUS_WIDTH  = 8
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_req,
   input  logic [BUS_WIDTH-1:0] i_unsync_bus,
   output logic [BUS_WIDTH-1:0] o_sync_bus,
   output logic                 o_valid_pulse,
   output logic                 o_ack,
   output logic                 o_busy
);

   typedef enum logic {
      IDLE = 1'b0,
      ACK  = 1'b1
   } state_t;

   state_t                state;
   state_t                next_state;
   logic [NUM_STAGES-1:0] sync_chain;
   logic                  req_s;
   logic                  capture;

   // Plain shift chain for the request; nothing sits between the stages
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         sync_chain <= '0;
      end else begin
         sync_chain <= {sync_chain[NUM_STAGES-2:0], i_req};
      end
   end

   assign req_s = sync_chain[NUM_STAGES-1];

   // State register
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic; a capture happens only on the IDLE-to-ACK step
   always_comb begin
      next_state = state;
      capture    = 1'b0;
      case (state)
         IDLE: begin
            if (req_s) begin
               next_state = ACK;
               capture    = 1'b1;
            end
         end
         ACK: begin
            if (!req_s) begin
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Registered outputs: the bus is sampled only at the capture edge and held
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         o_sync_bus    <= '0;
         o_valid_pulse <= 1'b0;
         o_ack         <= 1'b0;
      end else begin
         o_valid_pulse <= capture;
         o_ack         <= (next_state == ACK);
         if (capture) begin
            o_sync_bus <= i_unsync_bus;
         end
      end
   end

   assign o_busy = (state == ACK);

endmodule

// File: tb/tb_data_sync_rx.sv
// Directed testbench for data_sync_rx: one instance with the default
// parameters and one with NUM_STAGES=3, BUS_WIDTH=16, sharing clock and reset.
module tb_data_sync_rx;

   logic        clk;
   logic        rst_n;

   logic        req2;
   logic [7:0]  bus2;
   logic [7:0]  sync2;
   logic        pulse2;
   logic        ack2;
   logic        busy2;

   logic        req3;
   logic [15:0] bus3;
   logic [15:0] sync3;
   logic        pulse3;
   logic        ack3;
   logic        busy3;

   int checks;
   int failures;
   int pulse_count;

   data_sync_rx #(.NUM_STAGES(2), .BUS_WIDTH(8)) dut2 (
      .i_clk         (clk),
      .i_rst         (rst_n),
      .i_req         (req2),
      .i_unsync_bus  (bus2),
      .o_sync_bus    (sync2),
      .o_valid_pulse (pulse2),
      .o_ack         (ack2),
      .o_busy        (busy2)
   );

   data_sync_rx #(.NUM_STAGES(3), .BUS_WIDTH(16)) dut3 (
      .i_clk         (clk),
      .i_rst         (rst_n),
      .i_req         (req3),
      .i_unsync_bus  (bus3),
      .o_sync_bus    (sync3),
      .o_valid_pulse (pulse3),
      .o_ack         (ack3),
      .o_busy        (busy3)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Pulses are one cycle wide, so sampling on the falling edge sees each once
   always @(negedge clk) begin
      if (pulse2) pulse_count++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Waits a bounded number of cycles for the 2-stage instance to drop o_ack
   task automatic waitAckLow2(input string tag);
      for (int i = 0; i < 12 && ack2; i++) step();
      checkOutput(tag, {31'd0, ack2}, 32'd0);
   endtask

   // One full handshake on the 2-stage instance; returns the captured value
   task automatic applyStimulus(input logic [7:0] value, output logic [7:0] seen);
      logic found;
      found = 1'b0;
      seen  = 8'h00;
      bus2  = value;
      req2  = 1'b1;
      for (int i = 0; i < 12 && !found; i++) begin
         step();
         if (pulse2) begin
            found = 1'b1;
            seen  = sync2;
         end
      end
      checkOutput("b2b_pulse_seen", {31'd0, found}, 32'd1);
      req2 = 1'b0;
      waitAckLow2("b2b_ack_fall");
      repeat (4) step();
   endtask

   initial begin
      logic [7:0] seen;
      int         base_count;
      logic       extra_pulse;
      logic       bus_moved;

      checks      = 0;
      failures    = 0;
      pulse_count = 0;
      rst_n       = 1'b0;
      req2        = 1'b1;
      bus2        = 8'hFF;
      req3        = 1'b1;
      bus3        = 16'hFFFF;

      // Reset values with the request already asserted
      #2;
      checkOutput("rst_sync2", {24'd0, sync2}, 32'h00);
      checkOutput("rst_pulse2", {31'd0, pulse2}, 32'd0);
      checkOutput("rst_ack2", {31'd0, ack2}, 32'd0);
      repeat (4) step();
      checkOutput("rst_sync2_held", {24'd0, sync2}, 32'h00);
      checkOutput("rst_pulse2_held", {31'd0, pulse2}, 32'd0);
      checkOutput("rst_ack2_held", {31'd0, ack2}, 32'd0);
      checkOutput("rst_busy2_held", {31'd0, busy2}, 32'd0);
      checkOutput("rst_sync3_held", {16'd0, sync3}, 32'h0000);
      checkOutput("rst_ack3_held", {31'd0, ack3}, 32'd0);
      req2 = 1'b0;
      req3 = 1'b0;
      step();
      rst_n = 1'b1;
      repeat (3) step();
      checkOutput("idle_pulse2", {31'd0, pulse2}, 32'd0);
      checkOutput("idle_ack2", {31'd0, ack2}, 32'd0);

      // Single transfer; edge numbering starts at the first sampling edge
      bus2 = 8'hA5;
      req2 = 1'b1;
      step();                                           // edge 1
      checkOutput("st_e1_pulse", {31'd0, pulse2}, 32'd0);
      step();                                           // edge 2
      checkOutput("st_e2_pulse", {31'd0, pulse2}, 32'd0);
      checkOutput("st_e2_ack", {31'd0, ack2}, 32'd0);
      step();                                           // edge 3
      checkOutput("st_e3_pulse", {31'd0, pulse2}, 32'd1);
      checkOutput("st_e3_sync", {24'd0, sync2}, 32'hA5);
      checkOutput("st_e3_ack", {31'd0, ack2}, 32'd1);
      checkOutput("st_e3_busy", {31'd0, busy2}, 32'd1);
      step();                                           // edge 4
      checkOutput("st_e4_pulse", {31'd0, pulse2}, 32'd0);
      checkOutput("st_e4_ack", {31'd0, ack2}, 32'd1);
      repeat (5) step();                                // edge 9
      req2 = 1'b0;
      step();                                           // edge 10
      checkOutput("st_e10_ack", {31'd0, ack2}, 32'd1);
      step();                                           // edge 11
      checkOutput("st_e11_ack", {31'd0, ack2}, 32'd1);
      step();                                           // edge 12
      checkOutput("st_e12_ack", {31'd0, ack2}, 32'd0);
      checkOutput("st_e12_busy", {31'd0, busy2}, 32'd0);
      checkOutput("st_e12_sync_held", {24'd0, sync2}, 32'hA5);
      repeat (4) step();

      // Hold: request stays high for 20 cycles while the bus moves
      bus2 = 8'hA5;
      req2 = 1'b1;
      repeat (3) step();
      checkOutput("hold_first_pulse", {31'd0, pulse2}, 32'd1);
      bus2        = 8'h3C;
      extra_pulse = 1'b0;
      bus_moved   = 1'b0;
      repeat (20) begin
         step();
         if (pulse2) extra_pulse = 1'b1;
         if (sync2 !== 8'hA5) bus_moved = 1'b1;
      end
      checkOutput("hold_no_second_pulse", {31'd0, extra_pulse}, 32'd0);
      checkOutput("hold_bus_kept", {31'd0, bus_moved}, 32'd0);
      checkOutput("hold_sync_value", {24'd0, sync2}, 32'hA5);
      checkOutput("hold_ack", {31'd0, ack2}, 32'd1);
      req2 = 1'b0;
      waitAckLow2("hold_ack_fall");
      repeat (4) step();

      // Back-to-back handshakes
      base_count = pulse_count;
      applyStimulus(8'h01, seen);
      checkOutput("b2b_val0", {24'd0, seen}, 32'h01);
      applyStimulus(8'h80, seen);
      checkOutput("b2b_val1", {24'd0, seen}, 32'h80);
      applyStimulus(8'hFF, seen);
      checkOutput("b2b_val2", {24'd0, seen}, 32'hFF);
      checkOutput("b2b_pulse_count", pulse_count - base_count, 32'd3);

      // Reset in the middle of a transfer with the request held high
      bus2 = 8'h5A;
      req2 = 1'b1;
      repeat (4) step();
      checkOutput("mr_in_ack", {31'd0, ack2}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("mr_ack_drop", {31'd0, ack2}, 32'd0);
      checkOutput("mr_busy_drop", {31'd0, busy2}, 32'd0);
      checkOutput("mr_sync_clear", {24'd0, sync2}, 32'h00);
      repeat (2) step();
      bus2  = 8'h77;
      rst_n = 1'b1;
      step();                                           // edge 1
      checkOutput("mr_e1_pulse", {31'd0, pulse2}, 32'd0);
      step();                                           // edge 2
      checkOutput("mr_e2_pulse", {31'd0, pulse2}, 32'd0);
      step();                                           // edge 3
      checkOutput("mr_e3_pulse", {31'd0, pulse2}, 32'd1);
      checkOutput("mr_e3_sync", {24'd0, sync2}, 32'h77);
      checkOutput("mr_e3_ack", {31'd0, ack2}, 32'd1);
      req2 = 1'b0;
      waitAckLow2("mr_ack_fall");
      repeat (4) step();

      // Three-stage, 16-bit instance
      bus3 = 16'hBEEF;
      req3 = 1'b1;
      repeat (3) step();                                // edge 3
      checkOutput("p3_e3_pulse", {31'd0, pulse3}, 32'd0);
      checkOutput("p3_e3_ack", {31'd0, ack3}, 32'd0);
      step();                                           // edge 4
      checkOutput("p3_e4_pulse", {31'd0, pulse3}, 32'd1);
      checkOutput("p3_e4_sync", {16'd0, sync3}, 32'hBEEF);
      checkOutput("p3_e4_ack", {31'd0, ack3}, 32'd1);
      step();                                           // edge 5
      checkOutput("p3_e5_pulse", {31'd0, pulse3}, 32'd0);
      repeat (3) step();                                // edge 8
      req3 = 1'b0;
      repeat (3) step();                                // edge 11
      checkOutput("p3_e11_ack", {31'd0, ack3}, 32'd1);
      step();                                           // edge 12
      checkOutput("p3_e12_ack", {31'd0, ack3}, 32'd0);
      checkOutput("p3_e12_sync_held", {16'd0, sync3}, 32'hBEEF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/data_sync_rx.md
# data_sync_rx

Destination-side receiver of the four-phase req/ack bus-crossing handshake. It resynchronises a level request from a foreign clock domain into `i_clk` and captures the accompanying multi-bit bus once the request is stable. It then issues a one-cycle valid pulse and returns a level acknowledge for the sender to resynchronise. It sits at the `i_clk` edge of every multi-bit CDC path, for example UART RX data and config words crossing into the system domain.

## Interface
- `NUM_STAGES`, default 2: flops in the request synchroniser chain; legal values are 2 or more.
- `BUS_WIDTH`, default 8: width of the crossed data bus.

- `i_clk`: input, 1 bit. Destination clock.
- `i_rst`: input, 1 bit. Reset, asynchronous, active-low.
- `i_req`: input, 1 bit. Asynchronous level request from the source domain.
- `i_unsync_bus`: input, `BUS_WIDTH` bits. Source data. The source holds it stable from `i_req` rise until it sees `o_ack` high.
- `o_sync_bus`: output, `BUS_WIDTH` bits. Captured data. Registered, and held between transfers.
- `o_valid_pulse`: output, 1 bit. Single-cycle strobe; `o_sync_bus` is valid in the same cycle.
- `o_ack`: output, 1 bit. Level acknowledge, registered, sent back to the source domain.
- `o_busy`: output, 1 bit. High while in the ACK state.

## Operation
- Synchroniser:
  - `i_req` passes through `NUM_STAGES` flops, all clocked by `i_clk`, giving `req_s` (the last stage).
  - No logic is placed between the stages.
  - `i_unsync_bus` is never synchronised; it is sampled only at the capture edge.
- State machine (2 states, IDLE and ACK):
  - IDLE, with `req_s`=1: next edge captures `o_sync_bus <= i_unsync_bus`, sets `o_valid_pulse`=1 and `o_ack`=1, and moves to ACK.
  - IDLE, with `req_s`=0: stay in IDLE. `o_valid_pulse`=0.
  - ACK, with `req_s`=1: stay in ACK. No further capture or pulse. `o_ack` stays 1.
  - ACK, with `req_s`=0: next edge clears `o_ack` to 0 and moves to IDLE.
- `o_valid_pulse` is exactly one cycle per transfer. It never asserts in ACK.
- `o_busy` = (state == ACK). It is registered, equivalent to `o_ack`.
- Protocol violation: if `i_req` drops and re-rises within fewer than `NUM_STAGES` cycles, it may be filtered out by the chain. The only requirement is that exactly 0 or 1 capture occurs per observed `req_s` high level.

## Timing
- Reset, with `i_rst` low and asynchronous:
  - All synchroniser flops = 0.
  - State = IDLE.
  - `o_sync_bus` = 0, `o_valid_pulse` = 0, `o_ack` = 0.
- Let edge k be the first `i_clk` edge that samples `i_req` = 1. Then `req_s` = 1 after edge k+`NUM_STAGES`-1.
  - Capture, `o_valid_pulse`, and `o_ack` rise all occur at edge k+`NUM_STAGES`.
  - Forward latency is therefore `NUM_STAGES`+1 edges, counting from the sampling edge inclusive.
  - Example: `NUM_STAGES`=2 gives a pulse in the cycle after the 2nd edge following the sampling edge.
- Let edge m be the first edge that samples `i_req` = 0 while in ACK. Then `o_ack` falls at edge m+`NUM_STAGES`.
- Back-to-back: a new `i_req` rise is honoured only once the FSM is back in IDLE. Minimum spacing is `NUM_STAGES`+1 cycles after the `o_ack` fall, plus the source's own ack sync delay.
- Reset asserted mid-transfer:
  - Outputs clear immediately; `o_ack` drops with no handshake completion.
  - If `i_req` is still high after release, it produces a fresh capture `NUM_STAGES`+1 edges after the first sampling edge.
- Reset release is expected to come from the system reset synchroniser, so deassertion is synchronous to `i_clk`.

## Test plan
- Reset values:
  - Stimulus: hold `i_rst`=0 with `i_req`=1 and `i_unsync_bus`=0xFF.
  - Required: `o_sync_bus`=0x00, `o_valid_pulse`=0, `o_ack`=0 throughout reset.
- Single transfer, `NUM_STAGES`=2:
  - Stimulus: `i_unsync_bus`=0xA5; `i_req` rises before edge 1.
  - Required: `o_sync_bus`=0xA5 and `o_valid_pulse`=1 after edge 3, for 1 cycle only. `o_ack`=1 from edge 3.
  - Stimulus: drop `i_req` before edge 10.
  - Required: `o_ack`=0 after edge 12.
- Hold behaviour:
  - Stimulus: keep `i_req`=1 for 20 cycles while changing the bus to 0x3C after capture.
  - Required: no second pulse. `o_sync_bus` stays 0xA5.
- Back-to-back transfers:
  - Stimulus: three full handshakes carrying 0x01, 0x80, 0xFF.
  - Required: exactly three pulses, carrying those values in order.
- Mid-transfer reset:
  - Stimulus: assert `i_rst` while in ACK with `i_req` held high, then release.
  - Required: `o_ack` drops immediately. A new capture and pulse occur `NUM_STAGES`+1 edges after release.
- Parameter sweep:
  - Stimulus: repeat the single-transfer scenario with `NUM_STAGES`=3 and `BUS_WIDTH`=16, value 0xBEEF.
  - Required: pulse after edge 4. `o_sync_bus`=0xBEEF.
